// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer.
// The state encoding is also what the front-panel LEDs show.
package alu_seq_pkg;

  localparam int OPCODE_W = 2;
  localparam int FLAGS_W  = 4;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for a clean, synchronous level input.
// Gives one pulse per press and never pulses on the first cycle after reset.
module edge_detector (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic r_in_q;
  logic r_armed;

  // r_armed stays low until the first sampled cycle after reset, so a button
  // already held while reset releases is seen as "previously high".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_q  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_in_q  <= in;
      r_armed <= 1'b1;
    end
  end

  assign pulse = in & ~r_in_q & r_armed;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects A, B and OpCode from switches on successive Enter presses,
// then latches the ALU result and flags for display until the next press.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    DataIn,
  input  logic                Enter,
  input  logic                Clear,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic [OPCODE_W-1:0] OpCode,
  input  logic [WIDTH-1:0]    ResultIn,
  input  logic                V,
  input  logic                C,
  input  logic                Z,
  input  logic                N,
  output logic [WIDTH-1:0]    ResultOut,
  output logic [FLAGS_W-1:0]  FlagsOut,
  output logic                Done,
  output logic [2:0]          StateOut
);

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [OPCODE_W-1:0]  r_opcode;
  logic [WIDTH-1:0]     r_result;
  logic [FLAGS_W-1:0]   r_flags;
  logic                 r_done;
  logic                 w_enter_pulse;

  edge_detector u_enter_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (Enter),
    .pulse   (w_enter_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= WAIT_A;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else if (Clear) begin
      r_state  <= WAIT_A;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (w_enter_pulse) begin
            r_a     <= DataIn;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_enter_pulse) begin
            r_b     <= DataIn;
            r_state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (w_enter_pulse) begin
            r_opcode <= DataIn[OPCODE_W-1:0];
            r_state  <= EXEC;
          end
        end
        // One cycle for the ALU to settle on the freshly registered operands.
        EXEC: begin
          r_result <= ResultIn;
          r_flags  <= {V, C, Z, N};
          r_done   <= 1'b1;
          r_state  <= SHOW;
        end
        SHOW: begin
          if (w_enter_pulse) begin
            r_done  <= 1'b0;
            r_state <= WAIT_A;
          end
        end
        default: r_state <= WAIT_A;
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign OpCode    = r_opcode;
  assign ResultOut = r_result;
  assign FlagsOut  = r_flags;
  assign Done      = r_done;
  assign StateOut  = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with an adder ALU stub and a
// Done-triggered scoreboard monitor.
module tb_alu_input_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] DataIn;
  logic       Enter;
  logic       Clear;
  logic [7:0] A, B;
  logic [1:0] OpCode;
  logic [7:0] ResultIn;
  logic       V, C, Z, N;
  logic [7:0] ResultOut;
  logic [3:0] FlagsOut;
  logic       Done;
  logic [2:0] StateOut;

  int errors = 0;
  int checks = 0;
  int n_done = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // ALU stub: 8-bit add regardless of OpCode.
  logic [8:0] sum;
  assign sum      = {1'b0, A} + {1'b0, B};
  assign ResultIn = sum[7:0];
  assign C        = sum[8];
  assign Z        = (sum[7:0] == 8'h00);
  assign N        = sum[7];
  assign V        = (A[7] == B[7]) && (sum[7] != A[7]);

  alu_input_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .DataIn    (DataIn),
    .Enter     (Enter),
    .Clear     (Clear),
    .A         (A),
    .B         (B),
    .OpCode    (OpCode),
    .ResultIn  (ResultIn),
    .V         (V),
    .C         (C),
    .Z         (Z),
    .N         (N),
    .ResultOut (ResultOut),
    .FlagsOut  (FlagsOut),
    .Done      (Done),
    .StateOut  (StateOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [7:0] d);
    @(negedge clk);
    DataIn = d;
    Enter  = 1'b1;
    @(negedge clk);
    Enter  = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opd,
                        input logic [7:0] res, input logic [3:0] flags);
    exp_t e;
    press(a);
    chk("load_a", A, a);
    chk("state_wait_b", StateOut, 3'd1);
    press(b);
    chk("load_b", B, b);
    chk("state_wait_op", StateOut, 3'd2);
    e = '{a: a, b: b, op: opd[1:0], res: res, flags: flags};
    exp_q.push_back(e);
    press(opd);
    chk("load_op", OpCode, opd[1:0]);
    chk("state_exec", StateOut, 3'd3);
    chk("done_low_exec", Done, 1'b0);
    @(negedge clk);
    chk("state_show", StateOut, 3'd4);
    chk("done_show", Done, 1'b1);
  endtask

  task automatic leave_show(input logic [7:0] a_keep, input logic [7:0] res_keep);
    press(8'hAA);
    chk("state_back_a", StateOut, 3'd0);
    chk("done_cleared", Done, 1'b0);
    chk("a_retained", A, a_keep);
    chk("res_retained", ResultOut, res_keep);
  endtask

  // Monitor: compare against the scoreboard on each rising Done.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && Done && !done_prev) begin
        n_done++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done=1 required no pending result");
        end else begin
          e = exp_q.pop_front();
          chk("mon_a", A, e.a);
          chk("mon_b", B, e.b);
          chk("mon_op", OpCode, e.op);
          chk("mon_result", ResultOut, e.res);
          chk("mon_flags", FlagsOut, e.flags);
          $display("txn A=%02h B=%02h op=%0d -> result=%02h flags=%04b", A, B, OpCode, ResultOut, FlagsOut);
        end
      end
      done_prev = Done;
    end
  end

  initial begin
    reset_n = 1'b0;
    DataIn  = 8'h00;
    Enter   = 1'b0;
    Clear   = 1'b0;
    #3;
    chk("rst_state", StateOut, 3'd0);
    chk("rst_a", A, 8'h00);
    chk("rst_done", Done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(8'h12, 8'h34, 8'h00, 8'h46, 4'b0000);
    leave_show(8'h12, 8'h46);
    run_op(8'h7F, 8'h01, 8'hFD, 8'h80, 4'b1001);
    leave_show(8'h7F, 8'h80);
    run_op(8'hFF, 8'h01, 8'h03, 8'h00, 4'b0110);
    leave_show(8'hFF, 8'h00);
    run_op(8'h80, 8'h80, 8'h02, 8'h00, 4'b1110);
    leave_show(8'h80, 8'h00);

    // Enter held for 20 cycles loads only A.
    @(negedge clk);
    DataIn = 8'h55;
    Enter  = 1'b1;
    @(negedge clk);
    DataIn = 8'h66;
    repeat (19) @(negedge clk);
    Enter = 1'b0;
    @(negedge clk);
    chk("hold_a", A, 8'h55);
    chk("hold_state", StateOut, 3'd1);
    chk("hold_b", B, 8'h80);

    // Clear coinciding with the OpCode press wins.
    press(8'h11);
    chk("pre_clear_state", StateOut, 3'd2);
    @(negedge clk);
    DataIn = 8'h02;
    Enter  = 1'b1;
    Clear  = 1'b1;
    @(negedge clk);
    Enter  = 1'b0;
    Clear  = 1'b0;
    chk("clear_state", StateOut, 3'd0);
    chk("clear_a", A, 8'h00);
    chk("clear_b", B, 8'h00);
    chk("clear_op", OpCode, 2'd0);
    chk("clear_done", Done, 1'b0);
    @(negedge clk);

    // Asynchronous reset in SHOW, Enter held through release.
    run_op(8'h20, 8'h0F, 8'h00, 8'h2F, 4'b0000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", StateOut, 3'd0);
    chk("arst_a", A, 8'h00);
    chk("arst_b", B, 8'h00);
    chk("arst_result", ResultOut, 8'h00);
    chk("arst_flags", FlagsOut, 4'h0);
    chk("arst_done", Done, 1'b0);
    DataIn = 8'h33;
    Enter  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_enter_state", StateOut, 3'd0);
    chk("held_enter_a", A, 8'h00);
    Enter = 1'b0;
    @(negedge clk);
    press(8'h09);
    chk("post_rst_a", A, 8'h09);
    chk("post_rst_state", StateOut, 3'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_events", n_done, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
